// File: rtl/itype_exec_ctrl_if.sv
// rtl/itype_exec_ctrl_if.sv - decode, register-file and ALU signal bundle of the OP-IMM sequencer
interface itype_exec_ctrl_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            rf_re;
  logic [RA_W-1:0] rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic [31:0]     alu_instr;
  logic [XLEN-1:0] alu_rv1;
  logic [XLEN-1:0] alu_imm;
  logic [XLEN-1:0] alu_result;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            done;
  logic            illegal;
  logic            busy;

  modport slave (
    input  flush, in_valid, in_instr, rf_rdata, alu_result,
    output in_ready, rf_re, rf_raddr, alu_instr, alu_rv1, alu_imm,
           rf_we, rf_waddr, rf_wdata, done, illegal, busy
  );

  modport master (
    output flush, in_valid, in_instr, rf_rdata, alu_result,
    input  in_ready, rf_re, rf_raddr, alu_instr, alu_rv1, alu_imm,
           rf_we, rf_waddr, rf_wdata, done, illegal, busy
  );
endinterface

// File: rtl/itype_exec_ctrl.sv
// rtl/itype_exec_ctrl.sv - OP-IMM sequencer: accept, read rs1, drive ALU, write back rd
// Optional ITYPE_BYPASS_EN: a last-write bypass register lets a dependent op skip the READ state.
module itype_exec_ctrl #(
  parameter int         XLEN      = 32,
  parameter int         RA_W      = 5,
  parameter logic [6:0] OPC_OPIMM = 7'h13
) (
  input  logic          clk,
  input  logic          rst_n,
  itype_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [31:0]     instr_q;
  logic            illegal_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] exec_rv1;
  logic [RA_W-1:0] in_rs1;
  logic [RA_W-1:0] wb_rd;
  logic [2:0]      in_f3;
  logic [6:0]      in_f7;
  logic            accept;
  logic            bad_op;
  logic            byp_hit;
  logic            wb_fire;
  logic            wb_write;

  assign in_rs1 = bus.in_instr[19:15];
  assign in_f3  = bus.in_instr[14:12];
  assign in_f7  = bus.in_instr[31:25];
  assign wb_rd  = instr_q[11:7];

  assign bus.in_ready = (state == S_IDLE) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Shift encodings reserve funct7; everything else only needs the right opcode.
  always_comb begin
    bad_op = 1'b0;
    if (bus.in_instr[6:0] != OPC_OPIMM)
      bad_op = 1'b1;
    else if (in_f3 == 3'b001 && in_f7 != 7'b0000000)
      bad_op = 1'b1;
    else if (in_f3 == 3'b101 && in_f7 != 7'b0000000 && in_f7 != 7'b0100000)
      bad_op = 1'b1;
  end

`ifdef ITYPE_BYPASS_EN
  logic            byp_valid;
  logic [RA_W-1:0] byp_rd;
  logic [XLEN-1:0] byp_data;
  logic            byp_use_q;

  // Holds the last value this block wrote; the RF copy is identical, so only flush needs to kill it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_valid <= 1'b0;
      byp_rd    <= '0;
      byp_data  <= '0;
    end else if (bus.flush) begin
      byp_valid <= 1'b0;
    end else if (wb_write) begin
      byp_valid <= 1'b1;
      byp_rd    <= wb_rd;
      byp_data  <= result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      byp_use_q <= 1'b0;
    else if (accept)
      byp_use_q <= byp_hit && !bad_op;
  end

  assign byp_hit  = byp_valid && (in_rs1 != '0) && (in_rs1 == byp_rd);
  assign exec_rv1 = byp_use_q ? byp_data : bus.rf_rdata;
`else
  assign byp_hit  = 1'b0;
  assign exec_rv1 = bus.rf_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_op)
            state_nx = S_WB;
          else if (byp_hit)
            state_nx = S_EXEC;
          else
            state_nx = S_READ;
        end
      end
      S_READ:  state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (bus.flush)
      state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        instr_q   <= bus.in_instr;
        illegal_q <= bad_op;
      end
      if (state == S_EXEC)
        result_q <= bus.alu_result;
    end
  end

  // A flush landing on WB kills both the write and the completion pulse.
  assign wb_fire  = (state == S_WB) && !bus.flush;
  assign wb_write = wb_fire && !illegal_q && (wb_rd != '0);

  assign bus.rf_re     = (state == S_READ);
  assign bus.rf_raddr  = instr_q[19:15];
  assign bus.alu_instr = instr_q;
  assign bus.alu_imm   = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign bus.alu_rv1   = (state == S_EXEC) ? exec_rv1 : '0;
  assign bus.rf_we     = wb_write;
  assign bus.rf_waddr  = wb_rd;
  assign bus.rf_wdata  = result_q;
  assign bus.done      = wb_fire;
  assign bus.illegal   = wb_fire && illegal_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_itype_exec_ctrl.sv
// tb/tb_itype_exec_ctrl.sv - directed-vector bench with an op-level timeline model of the sequencer
module tb_itype_exec_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  itype_exec_ctrl_if ifc ();
  itype_exec_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rf_init(input int i);
    case (i)
      1:       return 32'd5;
      5:       return 32'hFFFF_FFF8;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    case (ins[14:12])
      3'd0:    return a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return ins[30] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic legal_op(input logic [31:0] i);
    if (i[6:0] != 7'h13) return 1'b0;
    if (i[14:12] == 3'd1) return i[31:25] == 7'd0;
    if (i[14:12] == 3'd5) return (i[31:25] == 7'd0) || (i[31:25] == 7'h20);
    return 1'b1;
  endfunction

  // Environment: synchronous-read register file and combinational ALU.
  logic [31:0] env_rf [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= rf_init(i);
      ifc.rf_rdata <= 32'd0;
    end else begin
      if (ifc.rf_we && ifc.rf_waddr != 5'd0) env_rf[ifc.rf_waddr] <= ifc.rf_wdata;
      if (ifc.rf_re) ifc.rf_rdata <= env_rf[ifc.rf_raddr];
    end
  end
  assign ifc.alu_result = alu(ifc.alu_instr, ifc.alu_rv1, ifc.alu_imm);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Model: one in-flight op described by its accept, read and writeback cycles.
  logic [31:0] mrf [32];
  logic        m_active, m_ill, m_we, bv;
  logic [4:0]  m_rd, m_rs1, brd;
  logic [31:0] m_val, m_a, m_imm, m_ins;
  int          m_acc, m_rdc, m_wb;
  logic        e_done;

  int          obs_done_cyc, obs_done_cnt, obs_we_cnt, obs_re_cnt;
  logic        obs_ill;
  logic [31:0] obs_wdata;
  logic [4:0]  obs_waddr, obs_raddr;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      bv       = 1'b0;
      for (int i = 0; i < 32; i++) mrf[i] = rf_init(i);
    end else begin
      e_done = m_active && (cyc == m_wb) && !ifc.flush;
      chk("in_ready", 32'(ifc.in_ready), 32'(!m_active && !ifc.flush));
      chk("busy", 32'(ifc.busy), 32'(m_active));
      chk("rf_re", 32'(ifc.rf_re), 32'(m_active && cyc == m_rdc));
      if (m_active && cyc == m_rdc) chk("rf_raddr", 32'(ifc.rf_raddr), 32'(m_rs1));
      chk("done", 32'(ifc.done), 32'(e_done));
      chk("illegal", 32'(ifc.illegal), 32'(e_done && m_ill));
      chk("rf_we", 32'(ifc.rf_we), 32'(e_done && m_we));
      if (e_done && m_we) begin
        chk("rf_waddr", 32'(ifc.rf_waddr), 32'(m_rd));
        chk("rf_wdata", ifc.rf_wdata, m_val);
      end
      if (m_active && !m_ill) begin
        chk("alu_instr", ifc.alu_instr, m_ins);
        chk("alu_imm", ifc.alu_imm, m_imm);
        if (cyc == m_wb - 1) chk("alu_rv1", ifc.alu_rv1, m_a);
      end

      if (ifc.done) begin
        obs_done_cyc = cyc;
        obs_done_cnt++;
        obs_ill = ifc.illegal;
      end
      if (ifc.rf_we) begin
        obs_we_cnt++;
        obs_wdata = ifc.rf_wdata;
        obs_waddr = ifc.rf_waddr;
      end
      if (ifc.rf_re) begin
        obs_re_cnt++;
        obs_raddr = ifc.rf_raddr;
      end

      if (m_active) begin
        if (ifc.flush || cyc == m_wb) begin
          if (e_done && m_we) begin
            mrf[m_rd] = m_val;
            bv  = 1'b1;
            brd = m_rd;
          end
          m_active = 1'b0;
        end
      end else if (ifc.in_valid && !ifc.flush) begin
        m_active = 1'b1;
        m_ins    = ifc.in_instr;
        m_rs1    = m_ins[19:15];
        m_rd     = m_ins[11:7];
        m_imm    = {{20{m_ins[31]}}, m_ins[31:20]};
        m_a      = (m_rs1 == 5'd0) ? 32'd0 : mrf[m_rs1];
        m_val    = alu(m_ins, m_a, m_imm);
        m_ill    = !legal_op(m_ins);
        m_we     = !m_ill && (m_rd != 5'd0);
        m_acc    = cyc;
        m_rdc    = cyc + 1;
        m_wb     = cyc + 3;
        if (m_ill) begin
          m_rdc = -1;
          m_wb  = cyc + 1;
        end
`ifdef ITYPE_BYPASS_EN
        else if (bv && m_rs1 != 5'd0 && m_rs1 == brd) begin
          m_rdc = -1;
          m_wb  = cyc + 2;
        end
`endif
      end
      if (ifc.flush) bv = 1'b0;
    end
  end

  int acc_cyc;

  task automatic issue(input logic [31:0] ins);
    int n = 0;
    while (!ifc.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ifc.in_ready) begin
      timeout("issue");
      return;
    end
    ifc.in_valid = 1'b1;
    ifc.in_instr = ins;
    acc_cyc = cyc;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ifc.in_ready && !ifc.busy) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(ifc.in_ready && !ifc.busy)) timeout("wait_idle");
  endtask

  task automatic issue_flush(input logic [31:0] ins, input int k);
    issue(ins);
    repeat (k - 1) @(posedge clk);
    #1 ifc.flush = 1'b1;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
  endtask

  logic [31:0] misc_ops [9] = '{32'h0F00C493, 32'h8000A513, 32'hFFF2B593, 32'h00F2F613,
                                32'h01F31693, 32'h0042D713, 32'h00000033, 32'h0210D093,
                                32'h00536793};
  int re0, we0, d0;

  initial begin
    obs_done_cnt = 0; obs_we_cnt = 0; obs_re_cnt = 0; obs_done_cyc = 0;
    obs_ill = 1'b0; obs_wdata = 32'd0; obs_waddr = 5'd0; obs_raddr = 5'd0;
    rst_n = 1'b0;
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_instr = 32'd0;
    #23;
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_rf_re", 32'(ifc.rf_re), 32'd0);
    chk("rst_rf_we", 32'(ifc.rf_we), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_illegal", 32'(ifc.illegal), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_alu_imm", ifc.alu_imm, 32'd0);
    chk("rst_rf_wdata", ifc.rf_wdata, 32'd0);
    chk("rst_rf_waddr", 32'(ifc.rf_waddr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // srai x6,x5,2 with x5 = -8
    issue(32'h4022D313); wait_idle();
    chk("t2_wdata", obs_wdata, 32'hFFFF_FFFE);
    chk("t2_waddr", 32'(obs_waddr), 32'd6);
    chk("t2_latency", obs_done_cyc - acc_cyc, 32'd3);
    chk("t2_illegal", 32'(obs_ill), 32'd0);

    // addi x5,x1,-1 with x1 = 5
    issue(32'hFFF08293); wait_idle();
    chk("t1_raddr", 32'(obs_raddr), 32'd1);
    chk("t1_waddr", 32'(obs_waddr), 32'd5);
    chk("t1_wdata", obs_wdata, 32'd4);
    chk("t1_latency", obs_done_cyc - acc_cyc, 32'd3);

    // slli with funct7 = 0100000 is illegal
    re0 = obs_re_cnt; we0 = obs_we_cnt;
    issue(32'h40109093); wait_idle();
    chk("t3_latency", obs_done_cyc - acc_cyc, 32'd1);
    chk("t3_illegal", 32'(obs_ill), 32'd1);
    chk("t3_no_read", obs_re_cnt, re0);
    chk("t3_no_write", obs_we_cnt, we0);

    // addi x0,x1,1 then addi x7,x0,0
    we0 = obs_we_cnt;
    issue(32'h00108013); wait_idle();
    chk("t4_latency", obs_done_cyc - acc_cyc, 32'd3);
    chk("t4_no_write", obs_we_cnt, we0);
    re0 = obs_re_cnt;
    issue(32'h00000393); wait_idle();
    chk("t4_x0_read", obs_re_cnt, re0 + 1);
    chk("t4_x0_raddr", 32'(obs_raddr), 32'd0);
    chk("t4_x7_wdata", obs_wdata, 32'd0);

    // flush in EXEC, then addi x8,x7,2 must read the RF
    d0 = obs_done_cnt; we0 = obs_we_cnt;
    issue_flush(32'hFFF08293, 2); wait_idle();
    chk("t5_no_done", obs_done_cnt, d0);
    chk("t5_no_write", obs_we_cnt, we0);
    re0 = obs_re_cnt;
    issue(32'h00238413); wait_idle();
    chk("t5_reads_rf", obs_re_cnt, re0 + 1);
    chk("t5_wdata", obs_wdata, 32'd2);
    chk("t5_latency", obs_done_cyc - acc_cyc, 32'd3);

    // addi x5,x1,-1 then dependent addi x6,x5,3 back-to-back
    issue(32'hFFF08293); wait_idle();
    re0 = obs_re_cnt;
    issue(32'h00328313); wait_idle();
    chk("t6_wdata", obs_wdata, 32'd7);
`ifdef ITYPE_BYPASS_EN
    chk("t6_latency", obs_done_cyc - acc_cyc, 32'd2);
    chk("t6_reads", obs_re_cnt, re0);
`else
    chk("t6_latency", obs_done_cyc - acc_cyc, 32'd3);
    chk("t6_reads", obs_re_cnt, re0 + 1);
`endif

    foreach (misc_ops[i]) issue(misc_ops[i]);
    wait_idle();

    // flush in READ and on WB
    issue_flush(32'h0F00C493, 1); wait_idle();
    d0 = obs_done_cnt; we0 = obs_we_cnt;
    issue_flush(32'h00F2F613, 3); wait_idle();
    chk("wbflush_no_done", obs_done_cnt, d0);
    chk("wbflush_no_write", obs_we_cnt, we0);

    // flush in IDLE blocks acceptance
    d0 = obs_done_cnt;
    ifc.flush = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'hFFF08293;
    @(posedge clk); #1;
    ifc.flush = 1'b0;
    ifc.in_valid = 1'b0;
    chk("idleflush_not_busy", 32'(ifc.busy), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("idleflush_no_done", obs_done_cnt, d0);

    issue(32'h00328313); wait_idle();
    issue(32'h0042D713); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
